ddr2_v10_1_sequencer_phy_mgr_arb: RTL and testbench
===================================================

// Module: ddr2_v10_1_sequencer_phy_mgr_arb
// PURPOSE
//  Two-master Avalon-MM arbiter in front of the sequencer PHY manager slave port.
//  Shares the port between the sequencer CPU (m0) and the debug/JTAG master (m1).
//  Round-robin grant, one transaction per grant, and a forced one-cycle slave deselect
//  after every completion so the PHY manager's DONE state returns to IDLE.
//  Per-transaction watchdog terminates a hung slave access.
// PARAMETERS
//  AVL_DATA_WIDTH  32    Avalon data width, all ports
//  AVL_ADDR_WIDTH  16    Avalon address width, all ports
//  TIMEOUT_WIDTH   16    watchdog counter width
//  TIMEOUT_CYCLES  4096  GRANT cycles with s_waitrequest=1 before abort; 0 = watchdog off
// PORTS
//  avl_clk         in   1     single clock, all logic
//  avl_reset       in   1     synchronous, active-high reset
//  m0_address      in   AVL_ADDR_WIDTH  CPU master address
//  m0_read/m0_write in  1     CPU strobes; held until m0_waitrequest=0
//  m0_writedata    in   AVL_DATA_WIDTH  CPU write data
//  m0_readdata     out  AVL_DATA_WIDTH  valid in cycle m0_waitrequest=0 with m0_read=1
//  m0_waitrequest  out  1     CPU stall
//  m1_*            --   --    same set as m0_*, debug master
//  s_address       out  AVL_ADDR_WIDTH  to PHY manager
//  s_read/s_write  out  1     to PHY manager
//  s_writedata     out  AVL_DATA_WIDTH  to PHY manager
//  s_readdata      in   AVL_DATA_WIDTH  from PHY manager
//  s_waitrequest   in   1     from PHY manager
//  grant           out  2     one-hot current owner; 00 when IDLE/RELEASE
//  timeout_err     out  1     one-cycle pulse on watchdog abort
// BEHAVIOUR
//  req_i = mi_read | mi_write. States IDLE, GRANT, RELEASE; all state regs registered.
//  Reset: state=IDLE, last=1 (m0 wins first), grant=00, wd_cnt=0, timeout_err=0.
//   s_read=s_write=0, s_address=s_writedata=0; mi_waitrequest=req_i; mi_readdata=0.
//  IDLE: both req -> grant the master != last. One req -> that master. Set last and grant.
//   Go to GRANT next cycle, so arbitration latency is 1 cycle.
//   Slave strobes are 0 and mi_waitrequest=req_i.
//  GRANT: s_* driven combinationally from the granted master, so the slave sees the
//   strobes from the first GRANT cycle.
//   Granted mi_waitrequest = s_waitrequest and mi_readdata = s_readdata, both comb.
//   Ungranted master: waitrequest=req, readdata=0.
//   s_waitrequest=0 -> completion this cycle; next state RELEASE, wd_cnt=0.
//   If the granted master drops req before completion (protocol violation): go RELEASE.
//  Watchdog: wd_cnt increments each GRANT cycle with s_waitrequest=1.
//   When wd_cnt == TIMEOUT_CYCLES-1 and s_waitrequest is still 1, abort in that cycle:
//   mi_waitrequest=0, mi_readdata=all ones, timeout_err=1 next cycle, go RELEASE.
//   The counter saturates and never wraps.
//  RELEASE: exactly 1 cycle. s_read=s_write=0, grant=00, all mi_waitrequest=req_i.
//   Go to IDLE. A master that keeps requesting starts a new arbitration.
//  Back-to-back requests from both masters alternate m0,m1,m0,...
//   Minimum 3 cycles per transaction: IDLE, GRANT, RELEASE.
//  m_read and m_write both high: forwarded unchanged; the slave defines the priority.
//  Reset asserted mid-GRANT: strobes drop in the cycle after the reset edge, state=IDLE.
//   No timeout_err pulse.
// TESTING
//  Idle slave (waitreq low when deselected), m0 read addr 0x2000 -> s_read in cycle 2,
//   m0 sees readdata=slave data and waitreq=0 same cycle, grant 01->00.
//  m0 and m1 write in same cycle, held for 4 txns each -> grant order 01,10,01,10.
//   RELEASE cycle (s_write=0) present between each pair.
//  Slave holds waitreq 5 cycles on m1 write 0x3000 -> m1 waitreq high 5 GRANT cycles.
//   m0 request stalls until after RELEASE.
//  TIMEOUT_CYCLES=8, slave waitreq stuck high, m0 read -> abort on 8th GRANT cycle.
//   readdata=0xFFFFFFFF, timeout_err pulses once; with TIMEOUT_CYCLES=0 it never aborts.
//  avl_reset asserted during 3rd GRANT cycle -> s_read=0 next cycle, grant=00.
//   After release, m0 wins first even if m1 won last.
//  Protocol monitor: s_read/s_write never high in IDLE/RELEASE.
//   grant stays one-hot or 00; never two consecutive grants without a deselect cycle.

Source files
------------

// File: rtl/ddr2_v10_1_sequencer_phy_mgr_arb.sv
// ddr2_v10_1_sequencer_phy_mgr_arb
//   Two-master Avalon-MM arbiter in front of the sequencer PHY manager slave port.
//   m0 is the sequencer CPU, m1 the debug/JTAG master. Round-robin grant, one
//   transaction per grant, and a one-cycle deselect (RELEASE) after every
//   transaction so the PHY manager's DONE state can fall back to IDLE. A
//   per-transaction watchdog aborts a slave access that stalls too long.
// Ports
//   avl_clk, avl_reset        clock, synchronous active-high reset
//   m0_* / m1_*               Avalon-MM slave-side ports for the two masters
//   s_*                       Avalon-MM master-side port to the PHY manager
//   grant                     one-hot current owner, 00 outside GRANT
//   timeout_err               one-cycle pulse after a watchdog abort
module ddr2_v10_1_sequencer_phy_mgr_arb #(
    parameter int unsigned AVL_DATA_WIDTH = 32,
    parameter int unsigned AVL_ADDR_WIDTH = 16,
    parameter int unsigned TIMEOUT_WIDTH  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                      avl_clk,
    input  logic                      avl_reset,

    input  logic [AVL_ADDR_WIDTH-1:0] m0_address,
    input  logic                      m0_read,
    input  logic                      m0_write,
    input  logic [AVL_DATA_WIDTH-1:0] m0_writedata,
    output logic [AVL_DATA_WIDTH-1:0] m0_readdata,
    output logic                      m0_waitrequest,

    input  logic [AVL_ADDR_WIDTH-1:0] m1_address,
    input  logic                      m1_read,
    input  logic                      m1_write,
    input  logic [AVL_DATA_WIDTH-1:0] m1_writedata,
    output logic [AVL_DATA_WIDTH-1:0] m1_readdata,
    output logic                      m1_waitrequest,

    output logic [AVL_ADDR_WIDTH-1:0] s_address,
    output logic                      s_read,
    output logic                      s_write,
    output logic [AVL_DATA_WIDTH-1:0] s_writedata,
    input  logic [AVL_DATA_WIDTH-1:0] s_readdata,
    input  logic                      s_waitrequest,

    output logic [1:0]                grant,
    output logic                      timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RELEASE
    } state_t;

    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] WD_LIMIT =
        WD_EN ? TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    state_t                   state;
    state_t                   state_nxt;
    logic                     last;       // 1: m1 owned the port most recently
    logic [1:0]               grant_q;
    logic [TIMEOUT_WIDTH-1:0] wd_cnt;
    logic                     timeout_q;

    logic req0;
    logic req1;
    logic sel_m1;
    logic gnt_req;
    logic abort;

    assign req0    = m0_read | m0_write;
    assign req1    = m1_read | m1_write;
    // On a tie the master that did not own the port last wins.
    assign sel_m1  = req1 & (~req0 | ~last);
    assign gnt_req = grant_q[1] ? req1 : req0;
    assign abort   = WD_EN && (state == ST_GRANT) && gnt_req &&
                     s_waitrequest && (wd_cnt == WD_LIMIT);

    assign grant       = grant_q;
    assign timeout_err = timeout_q;

    // State register
    always_ff @(posedge avl_clk) begin
        if (avl_reset) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (req0 | req1) state_nxt = ST_GRANT;
            ST_GRANT:   if (!s_waitrequest || abort || !gnt_req) state_nxt = ST_RELEASE;
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Ownership, watchdog and error flag
    always_ff @(posedge avl_clk) begin
        if (avl_reset) begin
            last      <= 1'b1;
            grant_q   <= '0;
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= abort;
            unique case (state)
                ST_IDLE: begin
                    if (req0 | req1) begin
                        grant_q <= sel_m1 ? 2'b10 : 2'b01;
                        last    <= sel_m1;
                    end
                end
                ST_GRANT: begin
                    if (state_nxt != ST_GRANT) begin
                        grant_q <= '0;
                        wd_cnt  <= '0;
                    end else if (s_waitrequest && (wd_cnt != '1)) begin
                        // saturate so a disabled watchdog never wraps
                        wd_cnt <= wd_cnt + TIMEOUT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic: slave port and master responses
    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        m0_waitrequest = req0;
        m0_readdata    = '0;
        m1_waitrequest = req1;
        m1_readdata    = '0;
        if (state == ST_GRANT) begin
            if (grant_q[1]) begin
                s_address      = m1_address;
                s_read         = m1_read;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                m1_waitrequest = abort ? 1'b0 : s_waitrequest;
                m1_readdata    = abort ? '1 : s_readdata;
            end else begin
                s_address      = m0_address;
                s_read         = m0_read;
                s_write        = m0_write;
                s_writedata    = m0_writedata;
                m0_waitrequest = abort ? 1'b0 : s_waitrequest;
                m0_readdata    = abort ? '1 : s_readdata;
            end
        end
    end

endmodule

// File: tb/tb_ddr2_v10_1_sequencer_phy_mgr_arb.sv
// tb_ddr2_v10_1_sequencer_phy_mgr_arb
//   Scoreboard bench for the PHY manager arbiter. u_dut has an 8-cycle
//   watchdog and talks to a small slave model; u_nowd has the watchdog
//   disabled and shadows the same inputs. Expected read data and grant order
//   are queued when stimulus is issued and consumed by a negedge monitor.
module tb_ddr2_v10_1_sequencer_phy_mgr_arb;

    logic        avl_clk = 1'b0;
    logic        avl_reset = 1'b1;
    logic [15:0] m0_address = '0;
    logic        m0_read = 1'b0;
    logic        m0_write = 1'b0;
    logic [31:0] m0_writedata = '0;
    logic [31:0] m0_readdata;
    logic        m0_waitrequest;
    logic [15:0] m1_address = '0;
    logic        m1_read = 1'b0;
    logic        m1_write = 1'b0;
    logic [31:0] m1_writedata = '0;
    logic [31:0] m1_readdata;
    logic        m1_waitrequest;
    logic [15:0] s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic        s_waitrequest;
    logic [1:0]  grant;
    logic        timeout_err;

    logic [31:0] u1_m0_readdata;
    logic        u1_m0_waitrequest;
    logic [31:0] u1_m1_readdata;
    logic        u1_m1_waitrequest;
    logic [15:0] u1_s_address;
    logic        u1_s_read;
    logic        u1_s_write;
    logic [31:0] u1_s_writedata;
    logic [1:0]  u1_grant;
    logic        u1_timeout_err;

    always #5 avl_clk = ~avl_clk;

    ddr2_v10_1_sequencer_phy_mgr_arb #(
        .AVL_DATA_WIDTH(32), .AVL_ADDR_WIDTH(16),
        .TIMEOUT_WIDTH(16),  .TIMEOUT_CYCLES(8)
    ) u_dut (
        .avl_clk(avl_clk), .avl_reset(avl_reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_readdata(m0_readdata),
        .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_readdata(m1_readdata),
        .m1_waitrequest(m1_waitrequest),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_readdata(s_readdata),
        .s_waitrequest(s_waitrequest),
        .grant(grant), .timeout_err(timeout_err)
    );

    ddr2_v10_1_sequencer_phy_mgr_arb #(
        .AVL_DATA_WIDTH(32), .AVL_ADDR_WIDTH(16),
        .TIMEOUT_WIDTH(16),  .TIMEOUT_CYCLES(0)
    ) u_nowd (
        .avl_clk(avl_clk), .avl_reset(avl_reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_readdata(u1_m0_readdata),
        .m0_waitrequest(u1_m0_waitrequest),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_readdata(u1_m1_readdata),
        .m1_waitrequest(u1_m1_waitrequest),
        .s_address(u1_s_address), .s_read(u1_s_read), .s_write(u1_s_write),
        .s_writedata(u1_s_writedata), .s_readdata(s_readdata),
        .s_waitrequest(s_waitrequest),
        .grant(u1_grant), .timeout_err(u1_timeout_err)
    );

    // ---------------- slave model (16-word register file) ----------------
    logic [31:0] slave_mem [16];
    int unsigned slave_cnt;
    int unsigned slave_wait = 0;
    bit          slave_stuck = 1'b0;
    logic        s_strobe;

    assign s_strobe      = s_read | s_write;
    assign s_waitrequest = slave_stuck || (s_strobe && (slave_cnt < slave_wait));
    assign s_readdata    = slave_mem[s_address[3:0]];

    always @(posedge avl_clk) begin
        if (avl_reset) begin
            for (int i = 0; i < 16; i++) slave_mem[i] <= 32'hC0DE_0000 | 32'(i);
            slave_cnt <= 0;
        end else if (s_strobe && !s_waitrequest) begin
            if (s_write) slave_mem[s_address[3:0]] <= s_writedata;
            slave_cnt <= 0;
        end else if (s_strobe) begin
            slave_cnt <= slave_cnt + 1;
        end else begin
            slave_cnt <= 0;
        end
    end

    // ---------------- scoreboard state ----------------
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    logic [31:0] ref_mem [16];
    logic [31:0] exp_rd0 [$];
    logic [31:0] exp_rd1 [$];
    logic [1:0]  exp_grant [$];
    logic [1:0]  prev_grant = '0;
    int unsigned m1_stall = 0;
    int unsigned tmo0 = 0;
    int unsigned tmo1 = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- monitor ----------------
    always @(negedge avl_clk) begin
        check_eq("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        check_eq("strobe_without_grant", 32'((s_read | s_write) && (grant == 2'b00)), 32'd0);
        check_eq("grant_switch_no_gap",
                 32'((prev_grant != 2'b00) && (grant != 2'b00) && (grant != prev_grant)), 32'd0);
        if ((grant != 2'b00) && (prev_grant == 2'b00)) begin
            check_eq("grant_expected", 32'(exp_grant.size() != 0), 32'd1);
            if (exp_grant.size() != 0) check_eq("grant_order", 32'(grant), 32'(exp_grant.pop_front()));
        end
        if (m0_read && !m0_waitrequest) begin
            check_eq("m0_rd_expected", 32'(exp_rd0.size() != 0), 32'd1);
            if (exp_rd0.size() != 0) check_eq("m0_readdata", m0_readdata, exp_rd0.pop_front());
        end
        if (m1_read && !m1_waitrequest) begin
            check_eq("m1_rd_expected", 32'(exp_rd1.size() != 0), 32'd1);
            if (exp_rd1.size() != 0) check_eq("m1_readdata", m1_readdata, exp_rd1.pop_front());
        end
        if ((grant == 2'b10) && m1_waitrequest) m1_stall <= m1_stall + 1;
        if (timeout_err) tmo0 <= tmo0 + 1;
        if (u1_timeout_err) tmo1 <= tmo1 + 1;
        prev_grant <= grant;
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_master(input int m, input logic rd, input logic wr,
                              input logic [15:0] a, input logic [31:0] d);
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d;
        end
    endtask

    function automatic logic master_wait(input int m);
        return (m == 0) ? m0_waitrequest : m1_waitrequest;
    endfunction

    task automatic ref_init();
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'hC0DE_0000 | 32'(i);
    endtask

    task automatic do_reset();
        avl_reset = 1'b1;
        set_master(0, 1'b0, 1'b0, '0, '0);
        set_master(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge avl_clk);
        #1 avl_reset = 1'b0;
        ref_init();
    endtask

    // One transaction: issue, wait (bounded) for acceptance, drop strobes one
    // step after the next rising edge so a following call keeps req continuous.
    task automatic master_txn(input int m, input logic wr, input logic [15:0] addr,
                              input logic [31:0] data);
        int n = 0;
        if (wr) ref_mem[addr[3:0]] = data;
        else if (m == 0) exp_rd0.push_back(ref_mem[addr[3:0]]);
        else exp_rd1.push_back(ref_mem[addr[3:0]]);
        set_master(m, !wr, wr, addr, data);
        do begin
            @(negedge avl_clk);
            n++;
        end while (master_wait(m) && (n < 200));
        if (n >= 200) check_eq("txn_hang", 32'(master_wait(m)), 32'd0);
        @(posedge avl_clk);
        #1 set_master(m, 1'b0, 1'b0, '0, '0);
    endtask

    // ---------------- tests ----------------
    initial begin
        int gcnt;
        int n;
        int unsigned tmo_before;

        // Reset state, with m0 requesting so waitrequest must mirror req
        set_master(0, 1'b1, 1'b0, 16'h1234, 32'h5555_AAAA);
        repeat (2) @(posedge avl_clk);
        @(negedge avl_clk);
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
        check_eq("rst_s_read", 32'(s_read), 32'd0);
        check_eq("rst_s_write", 32'(s_write), 32'd0);
        check_eq("rst_s_address", 32'(s_address), 32'd0);
        check_eq("rst_s_writedata", s_writedata, 32'd0);
        check_eq("rst_m0_waitreq", 32'(m0_waitrequest), 32'd1);
        check_eq("rst_m0_readdata", m0_readdata, 32'd0);
        check_eq("rst_m1_waitreq", 32'(m1_waitrequest), 32'd0);
        do_reset();

        // 1: single m0 read, one-cycle arbitration latency
        ref_init();
        exp_rd0.push_back(ref_mem[0]);
        exp_grant.push_back(2'b01);
        set_master(0, 1'b1, 1'b0, 16'h2000, '0);
        @(negedge avl_clk);
        check_eq("t1_idle_grant", 32'(grant), 32'd0);
        check_eq("t1_idle_s_read", 32'(s_read), 32'd0);
        check_eq("t1_idle_waitreq", 32'(m0_waitrequest), 32'd1);
        @(negedge avl_clk);
        check_eq("t1_grant", 32'(grant), 32'd1);
        check_eq("t1_s_read", 32'(s_read), 32'd1);
        check_eq("t1_s_address", 32'(s_address), 32'h2000);
        check_eq("t1_waitreq", 32'(m0_waitrequest), 32'd0);
        @(posedge avl_clk);
        #1 set_master(0, 1'b0, 1'b0, '0, '0);
        @(negedge avl_clk);
        check_eq("t1_release_grant", 32'(grant), 32'd0);
        check_eq("t1_release_s_read", 32'(s_read), 32'd0);

        // 2: both masters write back-to-back, grants alternate
        do_reset();
        for (int k = 0; k < 4; k++) begin
            exp_grant.push_back(2'b01);
            exp_grant.push_back(2'b10);
        end
        fork
            for (int k = 0; k < 4; k++) master_txn(0, 1'b1, 16'h4004 + 16'(k), 32'h1000_0000 + 32'(k * 32'h111));
            for (int k = 0; k < 4; k++) master_txn(1, 1'b1, 16'h5008 + 16'(k), 32'h2000_0000 ^ (32'(k) << 8));
        join
        // cross read-back; m1 owned last so m0 goes first
        exp_grant.push_back(2'b01);
        exp_grant.push_back(2'b10);
        fork
            master_txn(0, 1'b0, 16'h0009, '0);
            master_txn(1, 1'b0, 16'h0006, '0);
        join
        check_eq("t2_grants_left", 32'(exp_grant.size()), 32'd0);

        // 3: slave stalls 5 cycles on m1 write, m0 queued behind it
        do_reset();
        slave_wait = 5;
        m1_stall = 0;
        exp_grant.push_back(2'b10);
        exp_grant.push_back(2'b01);
        fork
            master_txn(1, 1'b1, 16'h3000, 32'hDEAD_BEEF);
            begin
                @(posedge avl_clk);
                #1 master_txn(0, 1'b0, 16'h2004, '0);
            end
        join
        slave_wait = 0;
        check_eq("t3_m1_stall_cycles", 32'(m1_stall), 32'd5);
        exp_grant.push_back(2'b01);
        master_txn(0, 1'b0, 16'h0000, '0);

        // 4: stuck slave, watchdog aborts on the 8th GRANT cycle
        do_reset();
        slave_stuck = 1'b1;
        exp_rd0.push_back(32'hFFFF_FFFF);
        exp_grant.push_back(2'b01);
        set_master(0, 1'b1, 1'b0, 16'h0010, '0);
        gcnt = 0;
        n = 0;
        do begin
            @(negedge avl_clk);
            n++;
            if (grant == 2'b01) gcnt++;
        end while (m0_waitrequest && (n < 100));
        check_eq("t4_abort_seen", 32'(m0_waitrequest), 32'd0);
        check_eq("t4_abort_cycle", 32'(gcnt), 32'd8);
        check_eq("t4_nowd_still_waits", 32'(u1_m0_waitrequest), 32'd1);
        @(posedge avl_clk);
        #1 set_master(0, 1'b0, 1'b0, '0, '0);
        @(negedge avl_clk);
        check_eq("t4_timeout_pulse", 32'(timeout_err), 32'd1);
        @(negedge avl_clk);
        check_eq("t4_timeout_low", 32'(timeout_err), 32'd0);
        slave_stuck = 1'b0;
        repeat (3) @(negedge avl_clk);
        check_eq("t4_timeout_count", 32'(tmo0), 32'd1);

        // 5: reset during 3rd GRANT cycle of an m0 read (m0 now owns 'last')
        do_reset();
        tmo_before = tmo0;
        slave_wait = 10;
        exp_grant.push_back(2'b01);
        set_master(0, 1'b1, 1'b0, 16'h0001, '0);
        gcnt = 0;
        n = 0;
        do begin
            @(negedge avl_clk);
            n++;
            if (grant == 2'b01) gcnt++;
        end while ((gcnt < 3) && (n < 20));
        check_eq("t5_third_grant", 32'(gcnt), 32'd3);
        avl_reset = 1'b1;
        @(negedge avl_clk);
        check_eq("t5_s_read_dropped", 32'(s_read), 32'd0);
        check_eq("t5_grant_cleared", 32'(grant), 32'd0);
        check_eq("t5_waitreq_is_req", 32'(m0_waitrequest), 32'd1);
        @(posedge avl_clk);
        #1 avl_reset = 1'b0;
        set_master(0, 1'b0, 1'b0, '0, '0);
        ref_init();
        slave_wait = 0;
        exp_grant.push_back(2'b01);
        exp_grant.push_back(2'b10);
        fork
            master_txn(1, 1'b0, 16'h0002, '0);
            master_txn(0, 1'b0, 16'h0003, '0);
        join
        repeat (2) @(negedge avl_clk);
        check_eq("t5_no_timeout_on_reset", 32'(tmo0), 32'(tmo_before));

        // end-of-run bookkeeping
        check_eq("end_grants_left", 32'(exp_grant.size()), 32'd0);
        check_eq("end_rd0_left", 32'(exp_rd0.size()), 32'd0);
        check_eq("end_rd1_left", 32'(exp_rd1.size()), 32'd0);
        check_eq("nowd_never_aborts", 32'(tmo1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
        $fatal(1, "global timeout");
    end

endmodule
